// File: rtl/usr_pkg.sv
// Shared operation codes for the universal shift register.
// The mode field is 3 bits wide, and all eight codes are legal operations.
package usr_pkg;
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;
  localparam logic [2:0] MODE_INC  = 3'b111;
endpackage

// File: rtl/universal_shift_reg_if.sv
// Control and data bundle for universal_shift_reg.
// There is no handshake: en qualifies each rising edge, and the outputs are valid every cycle.
interface universal_shift_reg_if #(parameter int WIDTH = 8);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic             sout_l;
  logic             sout_r;
  logic             wrap;

  modport master (
    output en, mode, d, sin_r, sin_l,
    input  q, q_bar, sout_l, sout_r, wrap
  );

  modport slave (
    input  en, mode, d, sin_r, sin_l,
    output q, q_bar, sout_l, sout_r, wrap
  );
endinterface

// File: rtl/usr_dff_cell.sv
// Single storage bit with an asynchronous active-low reset to RST_BIT.
// The complement output is derived from the stored bit, so it cannot be out of step with q.
module usr_dff_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic nxt,
  output logic q,
  output logic q_bar
);
  logic r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_q <= RST_BIT;
    else      r_q <= nxt;
  end

  assign q     = r_q;
  assign q_bar = ~r_q;
endmodule

// File: rtl/universal_shift_reg.sv
// Multi-mode register supporting hold, load, shift, rotate, clear and increment,
// built from WIDTH storage cells plus a registered increment-wrap flag.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  universal_shift_reg_if.slave bus
);
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_q_bar;
  logic [WIDTH-1:0] w_nxt;
  logic             w_wrap_nxt;
  logic             r_wrap;
  logic [WIDTH-1:0] w_one;

  assign w_one = {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    w_nxt      = w_q;
    w_wrap_nxt = 1'b0;
    if (bus.en) begin
      case (bus.mode)
        MODE_HOLD: w_nxt = w_q;
        MODE_LOAD: w_nxt = bus.d;
        MODE_SHL:  w_nxt = {w_q[WIDTH-2:0], bus.sin_r};
        MODE_SHR:  w_nxt = {bus.sin_l, w_q[WIDTH-1:1]};
        MODE_ROL:  w_nxt = {w_q[WIDTH-2:0], w_q[WIDTH-1]};
        MODE_ROR:  w_nxt = {w_q[0], w_q[WIDTH-1:1]};
        MODE_CLR:  w_nxt = '0;
        MODE_INC: begin
          w_nxt      = w_q + w_one;
          w_wrap_nxt = &w_q;
        end
        default:   w_nxt = w_q;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    usr_dff_cell #(.RST_BIT(RESET_VAL[i])) u_cell (
      .clk   (clk),
      .rst   (rst),
      .nxt   (w_nxt[i]),
      .q     (w_q[i]),
      .q_bar (w_q_bar[i])
    );
  end

  // wrap is high only for the cycle that follows an all-ones increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_wrap <= 1'b0;
    else      r_wrap <= w_wrap_nxt;
  end

  assign bus.q      = w_q;
  assign bus.q_bar  = w_q_bar;
  assign bus.sout_l = w_q[WIDTH-1];
  assign bus.sout_r = w_q[0];
  assign bus.wrap   = r_wrap;
endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg (WIDTH=8, RESET_VAL=A5): an arithmetic reference
// model is compared on every falling edge, and literal expectations pin key points.
module tb_universal_shift_reg;
  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_on = 0;

  universal_shift_reg_if #(.WIDTH(W)) bus ();

  universal_shift_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: next value from plain arithmetic on an integer view of q
  int unsigned m_q;
  bit          m_wrap;

  always @(posedge clk or negedge rst) begin
    int unsigned t;
    if (!rst) begin
      m_q    = RV;
      m_wrap = 0;
    end else begin
      t      = m_q;
      m_wrap = 0;
      if (bus.en === 1'b1) begin
        case (int'(bus.mode))
          0: t = m_q;
          1: t = bus.d;
          2: t = (m_q * 2 + bus.sin_r) % 256;
          3: t = m_q / 2 + bus.sin_l * 128;
          4: t = (m_q * 2) % 256 + m_q / 128;
          5: t = m_q / 2 + (m_q % 2) * 128;
          6: t = 0;
          7: begin
            t      = (m_q + 1) % 256;
            m_wrap = (m_q == 255);
          end
          default: t = m_q;
        endcase
      end
      m_q = t;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_q",      bus.q,              8'(m_q));
      chk("model_q_bar",  bus.q_bar,          ~8'(m_q));
      chk("model_sout_l", {7'd0, bus.sout_l}, {7'd0, m_q[7]});
      chk("model_sout_r", {7'd0, bus.sout_r}, {7'd0, m_q[0]});
      chk("model_wrap",   {7'd0, bus.wrap},   {7'd0, m_wrap});
    end
  end

  // driver: present inputs, then settle 1 time unit after the rising edge
  task automatic step(input logic en, input logic [2:0] mode, input logic [7:0] d,
                      input logic sr, input logic sl);
    bus.en    = en;
    bus.mode  = mode;
    bus.d     = d;
    bus.sin_r = sr;
    bus.sin_l = sl;
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sr;
    logic       sl;
  } vec_t;

  vec_t vecs[12];

  initial begin
    rst       = 1'b1;
    bus.en    = 1'b0;
    bus.mode  = 3'b000;
    bus.d     = 8'h00;
    bus.sin_r = 1'b0;
    bus.sin_l = 1'b0;

    // 1: reset applied between edges takes effect at once
    #2 rst = 1'b0;
    #1;
    chk("rst_q",     bus.q,            8'hA5);
    chk("rst_q_bar", bus.q_bar,        8'h5A);
    chk("rst_wrap",  {7'd0, bus.wrap}, 8'h00);
    cmp_on = 1;
    #9 rst = 1'b1;
    step(0, 3'b001, 8'hFF, 1, 1);
    step(0, 3'b111, 8'hFF, 1, 1);
    step(0, 3'b110, 8'hFF, 1, 1);
    chk("hold_en0", bus.q, 8'hA5);

    // 2: load and shift left
    step(1, 3'b001, 8'h3C, 0, 0);
    chk("load_3c", bus.q, 8'h3C);
    step(1, 3'b010, 8'h00, 1, 0);
    chk("shl_1", bus.q, 8'h79);
    chk("sout_l_pre", {7'd0, bus.sout_l}, 8'h00);
    step(1, 3'b010, 8'h00, 0, 0);
    chk("shl_2", bus.q, 8'hF2);

    // 3: rotates and shift right
    step(1, 3'b001, 8'h81, 0, 0);
    step(1, 3'b100, 8'h00, 0, 0);
    chk("rol", bus.q, 8'h03);
    step(1, 3'b101, 8'h00, 0, 0);
    chk("ror", bus.q, 8'h81);
    step(1, 3'b011, 8'h00, 0, 0);
    chk("shr", bus.q, 8'h40);
    chk("q_bar_shr", bus.q_bar, 8'hBF);

    // 4: increment across the wrap point
    step(1, 3'b001, 8'hFE, 0, 0);
    step(1, 3'b111, 8'h00, 0, 0);
    chk("inc_ff", bus.q, 8'hFF);
    chk("inc_ff_wrap", {7'd0, bus.wrap}, 8'h00);
    step(1, 3'b111, 8'h00, 0, 0);
    chk("inc_00", bus.q, 8'h00);
    chk("inc_00_wrap", {7'd0, bus.wrap}, 8'h01);
    step(1, 3'b111, 8'h00, 0, 0);
    chk("inc_01", bus.q, 8'h01);
    chk("inc_01_wrap", {7'd0, bus.wrap}, 8'h00);

    // 5: synchronous clear ignores RESET_VAL; en=0 holds and drops wrap
    step(1, 3'b110, 8'h00, 0, 0);
    chk("clr", bus.q, 8'h00);
    step(1, 3'b001, 8'hFF, 0, 0);
    step(1, 3'b111, 8'h00, 0, 0);
    step(0, 3'b001, 8'h77, 0, 0);
    chk("en0_q", bus.q, 8'h00);
    chk("en0_wrap", {7'd0, bus.wrap}, 8'h00);

    // mixed directed vectors checked by the model only
    vecs = '{
      '{1'b1, 3'b001, 8'hC3, 1'b0, 1'b0}, '{1'b1, 3'b010, 8'h00, 1'b1, 1'b0},
      '{1'b1, 3'b011, 8'h00, 1'b0, 1'b1}, '{1'b1, 3'b100, 8'h00, 1'b0, 1'b0},
      '{1'b1, 3'b101, 8'h00, 1'b0, 1'b0}, '{1'b0, 3'b110, 8'h00, 1'b0, 1'b0},
      '{1'b1, 3'b111, 8'h00, 1'b0, 1'b0}, '{1'b1, 3'b000, 8'h99, 1'b1, 1'b1},
      '{1'b1, 3'b011, 8'h00, 1'b1, 1'b1}, '{1'b1, 3'b010, 8'h00, 1'b0, 1'b0},
      '{1'b1, 3'b101, 8'h00, 1'b0, 1'b0}, '{1'b1, 3'b100, 8'h00, 1'b0, 1'b0}
    };
    foreach (vecs[i]) step(vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].sr, vecs[i].sl);

    // 6: asynchronous reset in the middle of a shift sequence
    step(1, 3'b001, 8'h55, 0, 0);
    step(1, 3'b010, 8'h00, 1, 0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_q", bus.q, 8'hA5);
    chk("mid_rst_q_bar", bus.q_bar, 8'h5A);
    step(1, 3'b001, 8'h77, 0, 0);
    chk("rst_over_load", bus.q, 8'hA5);
    #3 rst = 1'b1;
    step(1, 3'b001, 8'h12, 0, 0);
    chk("post_rst_load", bus.q, 8'h12);

    @(negedge clk);
    cmp_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
